lvds_tx_serializer: RTL and testbench

Multi-channel LVDS transmit serializer. It is the transmit-side partner of the Stratix II LVDS receiver model in the same simulation library. Parallel words enter through a one-entry valid/ready holding stage, are loaded into per-channel shift registers on an internally generated word boundary, and leave MSB-first as serial bits on `tx_out`. A forwarded clock channel (`tx_outclock`) is serialized the same way, and a training mode sends a fixed word so the far-end receiver can lock its DPA and bitslip alignment.

---
 rtl/lvds_tx_pkg.sv | 32 +++
 rtl/lvds_tx_lane.sv | 33 +++
 rtl/lvds_tx_serializer.sv | 114 +++++++++++
 tb/tb_lvds_tx_serializer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared range limits and default frame patterns for the LVDS transmit serializer.
package lvds_tx_pkg;
  localparam int LVDS_F_MIN = 4;
  localparam int LVDS_F_MAX = 10;

  // Alternating 1/0 word with the first-transmitted bit (bit f-1) set.
  function automatic logic [LVDS_F_MAX-1:0] lvds_default_train(input int f);
    logic [LVDS_F_MAX-1:0] w;
    w = {LVDS_F_MAX{1'b0}};
    for (int i = 0; i < LVDS_F_MAX; i++) begin
      if (i < f) begin
        w[i] = (((f - 1 - i) % 2) == 0);
      end else begin
        w[i] = 1'b0;
      end
    end
    return w;
  endfunction

  function automatic logic [LVDS_F_MAX-1:0] lvds_default_outclock(input int f);
    logic [LVDS_F_MAX-1:0] w;
    w = {LVDS_F_MAX{1'b0}};
    for (int i = 0; i < LVDS_F_MAX; i++) begin
      if (i < f) begin
        w[i] = (i >= (f - (f / 2)));
      end else begin
        w[i] = 1'b0;
      end
    end
    return w;
  endfunction
endpackage

// File: rtl/lvds_tx_lane.sv
// One F-bit load/shift serializer stage; bit F-1 drives the serial output.
module lvds_tx_lane
  import lvds_tx_pkg::*;
#(
  parameter int F = LVDS_F_MIN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [F-1:0] d,
  output logic         q
);
  logic [F-1:0] sr_q;
  logic [F-1:0] sr_d;

  always_comb begin
    if (load) begin
      sr_d = d;
    end else begin
      sr_d = {sr_q[F-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= {F{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[F-1];
endmodule

// File: rtl/lvds_tx_serializer.sv
// Multi-lane LVDS transmit serializer: one-entry holding stage, frame counter,
// per-lane shift registers and a forwarded clock channel.
module lvds_tx_serializer
  import lvds_tx_pkg::*;
#(
  parameter int number_of_channels = 1,
  parameter int deserialization_factor = 4,
  parameter logic [deserialization_factor-1:0] train_word =
    deserialization_factor'(lvds_default_train(deserialization_factor)),
  parameter logic [deserialization_factor-1:0] outclock_pattern =
    deserialization_factor'(lvds_default_outclock(deserialization_factor))
) (
  input  logic                                             tx_fastclk,
  input  logic                                             tx_reset_n,
  input  logic [deserialization_factor*number_of_channels-1:0] tx_in,
  input  logic                                             tx_in_valid,
  output logic                                             tx_in_ready,
  input  logic                                             tx_train,
  output logic [number_of_channels-1:0]                    tx_out,
  output logic                                             tx_outclock,
  output logic                                             tx_frame,
  output logic                                             tx_underflow
);
  localparam int F  = deserialization_factor;
  localparam int N  = number_of_channels;
  localparam int W  = F * N;
  localparam int CW = $clog2(F);
  localparam logic [CW-1:0] CNT_LAST = CW'(F - 1);

  if (F < LVDS_F_MIN || F > LVDS_F_MAX) begin : g_bad_factor
    $error("lvds_tx_serializer: deserialization_factor out of range 4..10");
  end
  if (N < 1 || N > 16) begin : g_bad_channels
    $error("lvds_tx_serializer: number_of_channels out of range 1..16");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_full_q, hold_full_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          frame_q, frame_d;
  logic          underflow_q, underflow_d;
  logic          load_s;
  logic          accept_s;
  logic [W-1:0]  lane_d_s;

  // Drain on a data load edge happens before a same-edge accept, so a refill keeps hold_full set.
  always_comb begin
    load_s      = (cnt_q == CNT_LAST);
    tx_in_ready = !hold_full_q || (load_s && !tx_train);
    accept_s    = tx_in_valid && tx_in_ready;
    if (load_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
    if (load_s && !tx_train && hold_full_q) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end
    if (accept_s) begin
      hold_full_d = 1'b1;
      hold_d      = tx_in;
    end else begin
      hold_d      = hold_q;
    end
    frame_d     = load_s;
    underflow_d = load_s && !tx_train && !hold_full_q;
    for (int c = 0; c < N; c++) begin
      if (tx_train || !hold_full_q) begin
        lane_d_s[c*F +: F] = train_word;
      end else begin
        lane_d_s[c*F +: F] = hold_q[c*F +: F];
      end
    end
  end

  always_ff @(posedge tx_fastclk or negedge tx_reset_n) begin
    if (!tx_reset_n) begin
      cnt_q       <= {CW{1'b0}};
      hold_full_q <= 1'b0;
      hold_q      <= {W{1'b0}};
      frame_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      frame_q     <= frame_d;
      underflow_q <= underflow_d;
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_lane
    lvds_tx_lane #(.F(F)) u_lane (
      .clk   (tx_fastclk),
      .rst_n (tx_reset_n),
      .load  (load_s),
      .d     (lane_d_s[c*F +: F]),
      .q     (tx_out[c])
    );
  end

  lvds_tx_lane #(.F(F)) u_clk_lane (
    .clk   (tx_fastclk),
    .rst_n (tx_reset_n),
    .load  (load_s),
    .d     (outclock_pattern),
    .q     (tx_outclock)
  );

  assign tx_frame     = frame_q;
  assign tx_underflow = underflow_q;
endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Bench for lvds_tx_serializer: three configurations (F=4x1, F=8x1, F=10x3) against a frame-level model.
module tb_lvds_tx_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_v [3];
  logic        in_t [3];
  logic [29:0] in_d [3];
  logic [0:0]  o0, o1;
  logic [2:0]  o2;
  logic        oc0, oc1, oc2, fr0, fr1, fr2, un0, un1, un2, rd0, rd1, rd2;

  lvds_tx_serializer #(.number_of_channels(1), .deserialization_factor(4)) u_f4 (
    .tx_fastclk(clk), .tx_reset_n(rst_n), .tx_in(in_d[0][3:0]), .tx_in_valid(in_v[0]),
    .tx_in_ready(rd0), .tx_train(in_t[0]), .tx_out(o0), .tx_outclock(oc0),
    .tx_frame(fr0), .tx_underflow(un0));
  lvds_tx_serializer #(.number_of_channels(1), .deserialization_factor(8)) u_f8 (
    .tx_fastclk(clk), .tx_reset_n(rst_n), .tx_in(in_d[1][7:0]), .tx_in_valid(in_v[1]),
    .tx_in_ready(rd1), .tx_train(in_t[1]), .tx_out(o1), .tx_outclock(oc1),
    .tx_frame(fr1), .tx_underflow(un1));
  lvds_tx_serializer #(.number_of_channels(3), .deserialization_factor(10)) u_f10 (
    .tx_fastclk(clk), .tx_reset_n(rst_n), .tx_in(in_d[2]), .tx_in_valid(in_v[2]),
    .tx_in_ready(rd2), .tx_train(in_t[2]), .tx_out(o2), .tx_outclock(oc2),
    .tx_frame(fr2), .tx_underflow(un2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Frame-level reference state per configuration.
  int          m_cyc [3];
  int          m_pos [3];
  logic        m_full [3];
  logic        m_und [3];
  logic        m_frm [3];
  logic        m_loaded [3];
  logic [29:0] m_hold [3];
  logic [29:0] m_word [3];
  logic        exp_rdy [3];
  logic [6:0]  exp_v [3];
  logic [6:0]  obs_v [3];

  function automatic int f_of(int k);
    case (k)
      0:       return 4;
      1:       return 8;
      default: return 10;
    endcase
  endfunction

  function automatic int n_of(int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic logic [9:0] ref_train(int f);
    logic [9:0] w = '0;
    for (int b = 0; b < f; b++) w[b] = (((f - 1 - b) % 2) == 0);
    return w;
  endfunction

  function automatic logic [9:0] ref_ocl(int f);
    logic [9:0] w = '0;
    for (int b = 0; b < f; b++) w[b] = (b >= f - f / 2);
    return w;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cyc[k] = 0; m_pos[k] = 0; m_full[k] = 1'b0; m_und[k] = 1'b0;
      m_frm[k] = 1'b0; m_loaded[k] = 1'b0; m_hold[k] = '0; m_word[k] = '0;
    end
  endfunction

  function automatic logic model_ready(int k);
    logic load = ((m_cyc[k] + 1) % f_of(k)) == 0;
    return !m_full[k] || (load && !in_t[k]);
  endfunction

  function automatic void model_edge(int k);
    int f = f_of(k);
    logic load = ((m_cyc[k] + 1) % f) == 0;
    logic rdy = !m_full[k] || (load && !in_t[k]);
    logic [9:0] t1 = ref_train(f);
    logic [29:0] tw = '0;
    for (int c = 0; c < n_of(k); c++)
      for (int b = 0; b < f; b++) tw[c*f + b] = t1[b];
    m_und[k] = 1'b0;
    m_frm[k] = load;
    if (load) begin
      m_loaded[k] = 1'b1;
      m_pos[k] = 0;
      if (in_t[k]) m_word[k] = tw;
      else if (m_full[k]) begin m_word[k] = m_hold[k]; m_full[k] = 1'b0; end
      else begin m_word[k] = tw; m_und[k] = 1'b1; end
    end else begin
      m_pos[k]++;
    end
    if (in_v[k] && rdy) begin m_hold[k] = in_d[k]; m_full[k] = 1'b1; end
    m_cyc[k]++;
  endfunction

  function automatic logic [2:0] exp_out(int k);
    logic [2:0] r = 3'b000;
    int f = f_of(k);
    if (m_pos[k] < f)
      for (int c = 0; c < n_of(k); c++) r[c] = m_word[k][c*f + f - 1 - m_pos[k]];
    return r;
  endfunction

  function automatic logic exp_clk(int k);
    int f = f_of(k);
    logic [9:0] p = ref_ocl(f);
    if (!m_loaded[k] || m_pos[k] >= f) return 1'b0;
    return p[f - 1 - m_pos[k]];
  endfunction

  function automatic void sample_obs();
    obs_v[0] = {rd0, 2'b00, o0, oc0, fr0, un0};
    obs_v[1] = {rd1, 2'b00, o1, oc1, fr1, un1};
    obs_v[2] = {rd2, o2, oc2, fr2, un2};
  endfunction

  // One clock: ready sampled before the edge, other outputs on the following falling edge.
  task automatic step();
    logic r0, r1, r2;
    #1;
    for (int k = 0; k < 3; k++) exp_rdy[k] = model_ready(k);
    r0 = rd0; r1 = rd1; r2 = rd2;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    @(negedge clk);
    sample_obs();
    obs_v[0][6] = r0; obs_v[1][6] = r1; obs_v[2][6] = r2;
    for (int k = 0; k < 3; k++)
      exp_v[k] = {exp_rdy[k], exp_out(k), exp_clk(k), m_frm[k], m_und[k]};
    cyc++;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 3; k++) begin in_v[k] = 1'b0; in_t[k] = 1'b0; in_d[k] = '0; end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    sample_obs();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_v[k] !== 7'b1000000) begin
        errors++; $display("FAIL reset_state k=%0d got %b want %b", k, obs_v[k], 7'b1000000);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    repeat (16) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL idle k=%0d cyc=%0d got %b want %b", k, cyc, obs_v[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [2];
    logic got;
    words[0] = 4'hB; words[1] = 4'h6;
    for (int i = 0; i < 2; i++) begin
      in_v[0] = 1'b1; in_d[0] = {26'd0, words[i]};
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        step();
        got = exp_rdy[0];
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (obs_v[k] !== exp_v[k]) begin
            errors++; $display("FAIL b2b_send k=%0d cyc=%0d got %b want %b", k, cyc, obs_v[k], exp_v[k]);
          end
        end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL b2b_accept_timeout word=%0d got 0 want 1", i); end
    end
    in_v[0] = 1'b0;
    repeat (16) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL b2b_drain k=%0d cyc=%0d got %b want %b", k, cyc, obs_v[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    in_v[0] = 1'b1; in_d[0] = 30'($urandom);
    repeat (28) begin
      step();
      if (exp_rdy[0]) in_d[0] = 30'($urandom);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL backpressure k=%0d cyc=%0d got %b want %b", k, cyc, obs_v[k], exp_v[k]);
        end
      end
    end
    in_v[0] = 1'b0;
  endtask

  task automatic test_train();
    logic got = 1'b0;
    in_v[1] = 1'b1; in_d[1] = 30'h0A5;
    for (int w = 0; w < 20 && !got; w++) begin step(); got = exp_rdy[1]; end
    checks++;
    if (!got) begin errors++; $display("FAIL train_fill_timeout got 0 want 1"); end
    in_v[1] = 1'b0; in_t[1] = 1'b1;
    for (int i = 0; i < 36; i++) begin
      if (i == 8) in_t[1] = 1'b0;
      if (i == 27) in_t[1] = 1'b1;
      if (i == 30) in_t[1] = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL train k=%0d cyc=%0d got %b want %b", k, cyc, obs_v[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_multi_lane();
    in_v[2] = 1'b1; in_d[2] = {10'h3FF, 10'h000, 10'h2AA};
    repeat (44) begin
      step();
      if (exp_rdy[2]) in_d[2] = 30'($urandom);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL multi_lane k=%0d cyc=%0d got %b want %b", k, cyc, obs_v[k], exp_v[k]);
        end
      end
    end
    in_v[2] = 1'b0;
  endtask

  task automatic test_random();
    repeat (400) begin
      for (int k = 0; k < 3; k++) begin
        in_v[k] = ($urandom_range(0, 3) != 0);
        in_t[k] = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 1) == 1) in_d[k] = 30'($urandom);
      end
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL random k=%0d cyc=%0d got %b want %b", k, cyc, obs_v[k], exp_v[k]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 3; k++) begin in_v[k] = 1'b1; in_d[k] = 30'($urandom); end
    repeat (6) step();
    #2;
    rst_n = 1'b0;
    #1;
    sample_obs();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_v[k] !== 7'b1000000) begin
        errors++; $display("FAIL mid_reset k=%0d got %b want %b", k, obs_v[k], 7'b1000000);
      end
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (24) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL after_reset k=%0d cyc=%0d got %b want %b", k, cyc, obs_v[k], exp_v[k]);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_idle();
    test_back_to_back();
    test_backpressure();
    test_train();
    test_multi_lane();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
